// File: rtl/fpu_rr_arbiter_if.sv
// fpu_rr_arbiter_if: requester, response and fpu-side signals of the shared-fpu arbiter
interface fpu_rr_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    req_op;
    logic [32*N_REQ-1:0] req_a;
    logic [32*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]    rsp_valid;
    logic [N_REQ-1:0]    rsp_ready;
    logic [31:0]         rsp_data;
    logic [31:0]         fpu_data_1;
    logic [31:0]         fpu_data_2;
    logic                fpu_op;
    logic                fpu_valid;
    logic [31:0]         fpu_result;
    logic                busy;
    logic [IDW-1:0]      grant_id;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready, fpu_result,
        output req_ready, rsp_valid, rsp_data, fpu_data_1, fpu_data_2, fpu_op, fpu_valid, busy, grant_id
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready, fpu_result,
        input  req_ready, rsp_valid, rsp_data, fpu_data_1, fpu_data_2, fpu_op, fpu_valid, busy, grant_id
    );
endinterface

// File: rtl/fpu_rr_arbiter.sv
// fpu_rr_arbiter: round-robin sharing of one fixed-latency fpu among N_REQ requesters
module fpu_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int LAT   = 2,
    parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input logic          i_clk,
    input logic          i_rst_n,
    fpu_rr_arbiter_if.slave bus
);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [N_REQ-1:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_q;
    logic [IDW-1:0]   rr_q;
    logic [IDW-1:0]   grant_q;
    logic [IDW-1:0]   grant_d;
    logic             found_d;
    int               idx;
    logic [CW-1:0]    cnt_q;
    logic [N_REQ-1:0] rsp_valid_q;
    logic [31:0]      rsp_data_q;
    logic [31:0]      data_1_q;
    logic [31:0]      data_2_q;
    logic             op_q;

    // first valid requester starting at rr_q, wrapping past N_REQ-1
    always_comb begin
        found_d = 1'b0;
        grant_d = '0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_q) + k;
            idx = (idx >= N_REQ) ? idx - N_REQ : idx;
            if (!found_d && bus.req_valid[idx]) begin
                found_d = 1'b1;
                grant_d = IDW'(idx);
            end
        end
    end

    assign bus.req_ready  = (state_q == IDLE && found_d) ? (ONE << grant_d) : '0;
    assign bus.fpu_valid  = (state_q == ISSUE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.grant_id   = grant_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.fpu_data_1 = data_1_q;
    assign bus.fpu_data_2 = data_2_q;
    assign bus.fpu_op     = op_q;

    // grant, issue, count down the fpu latency, then hold the result until its owner takes it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            data_1_q    <= '0;
            data_2_q    <= '0;
            op_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (found_d) begin
                    data_1_q <= bus.req_a[32*grant_d +: 32];
                    data_2_q <= bus.req_b[32*grant_d +: 32];
                    op_q     <= bus.req_op[grant_d];
                    grant_q  <= grant_d;
                    state_q  <= ISSUE;
                end
                ISSUE: begin
                    cnt_q   <= CW'(LAT - 1);
                    state_q <= WAIT;
                end
                WAIT: if (cnt_q == '0) begin
                    rsp_data_q  <= bus.fpu_result;
                    rsp_valid_q <= ONE << grant_q;
                    state_q     <= RESP;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                RESP: if (bus.rsp_ready[grant_q]) begin
                    rsp_valid_q <= '0;
                    rr_q        <= (int'(grant_q) == N_REQ - 1) ? '0 : grant_q + 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
